// File: rtl/pp_sequencer_if.sv
// Command channel into the ping-pong sequencer: valid/ready handshake plus
// the opcode, prescaler divisor and bounce target that travel with it.
interface pp_sequencer_if #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned BNC_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [DIV_W-1:0] cmd_div;
    logic [BNC_W-1:0] cmd_bounces;

    modport master (
        output cmd_valid, cmd_op, cmd_div, cmd_bounces,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_div, cmd_bounces,
        output cmd_ready
    );
endinterface

// File: rtl/pp_sequencer.sv
// Command-driven controller for the 4-bit ping-pong counter: prescaled RUN,
// single STEP pulses, STOP, and auto-stop after a target number of bounces.
module pp_sequencer #(
    parameter int unsigned DIV_W = 8,
    parameter int unsigned BNC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pp_sequencer_if.slave    cmd,
    input  logic             cnt_dir,
    input  logic [3:0]       cnt_out,
    output logic             cnt_enable,
    output logic             busy,
    output logic             done,
    output logic [BNC_W-1:0] bounce_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_RUN  = 2'd1,
        OP_STEP = 2'd2,
        OP_STOP = 2'd3
    } op_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BNC_W-1:0] tgt_q, tgt_d;
    logic [BNC_W-1:0] bcnt_q, bcnt_d;

    op_e              op;
    logic             accept;
    logic             bounce;
    logic             tgt_hit;
    logic [BNC_W-1:0] bcnt_inc;

    // State register and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            div_q   <= '0;
            tgt_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            div_q   <= div_d;
            tgt_q   <= tgt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign cmd.cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign bounce_cnt    = bcnt_q;

    // Next-state, datapath update and decoded outputs
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        div_d      = div_q;
        tgt_d      = tgt_q;
        bcnt_d     = bcnt_q;
        cnt_enable = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = 1'b0;

        op       = op_e'(cmd.cmd_op);
        accept   = cmd.cmd_valid && cmd.cmd_ready;
        bcnt_inc = bcnt_q + BNC_W'(1);

        case (state_q)
            ST_RUN:  cnt_enable = (presc_q == div_q);
            ST_STEP: cnt_enable = 1'b1;
            default: cnt_enable = 1'b0;
        endcase

        // A bounce is the enable edge that makes the counter reverse
        bounce  = cnt_enable &&
                  ((cnt_dir && (cnt_out == 4'd15)) || (!cnt_dir && (cnt_out == 4'd0)));
        tgt_hit = bounce && (tgt_q != '0) && (bcnt_inc == tgt_q);
        if (bounce) begin
            bcnt_d = bcnt_inc;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && (op == OP_RUN)) begin
                    div_d   = DIV_W'(cmd.cmd_div);
                    tgt_d   = BNC_W'(cmd.cmd_bounces);
                    bcnt_d  = '0;
                    presc_d = '0;
                    state_d = ST_RUN;
                end else if (accept && (op == OP_STEP)) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                presc_d = (presc_q == div_q) ? '0 : presc_q + DIV_W'(1);
                // Reaching the bounce target wins over a simultaneous STOP
                if (tgt_hit) begin
                    state_d = ST_DONE;
                end else if (accept && (op == OP_STOP)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != ST_RUN) begin
            presc_d = '0;
        end
    end
endmodule

// File: tb/tb_pp_sequencer.sv
// Directed bench for pp_sequencer driving a behavioural ping-pong counter.
module tb_pp_sequencer;
    localparam int unsigned DIV_W = 8;
    localparam int unsigned BNC_W = 4;

    logic             clk;
    logic             rst_n;
    logic             cnt_dir;
    logic [3:0]       cnt_out;
    logic             cnt_enable;
    logic             busy;
    logic             done;
    logic [BNC_W-1:0] bounce_cnt;

    int total = 0;
    int bad   = 0;

    pp_sequencer_if #(.DIV_W(DIV_W), .BNC_W(BNC_W)) cmd_bus ();

    pp_sequencer #(.DIV_W(DIV_W), .BNC_W(BNC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd_bus),
        .cnt_dir    (cnt_dir),
        .cnt_out    (cnt_out),
        .cnt_enable (cnt_enable),
        .busy       (busy),
        .done       (done),
        .bounce_cnt (bounce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ping-pong counter: 0..15..0, reversing at the ends
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_out <= 4'd0;
            cnt_dir <= 1'b1;
        end else if (cnt_enable) begin
            if (cnt_dir && cnt_out == 4'd15) begin
                cnt_dir <= 1'b0;
                cnt_out <= 4'd14;
            end else if (!cnt_dir && cnt_out == 4'd0) begin
                cnt_dir <= 1'b1;
                cnt_out <= 4'd1;
            end else begin
                cnt_out <= cnt_dir ? cnt_out + 4'd1 : cnt_out - 4'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] dv, input logic [3:0] bn);
        cmd_bus.cmd_valid   = 1'b1;
        cmd_bus.cmd_op      = op;
        cmd_bus.cmd_div     = dv;
        cmd_bus.cmd_bounces = bn;
        tick();
        cmd_bus.cmd_valid   = 1'b0;
        cmd_bus.cmd_op      = 2'd0;
    endtask

    task automatic wait_out(input logic [3:0] v);
        int n = 0;
        while (cnt_out != v && n < 100) begin
            tick();
            n++;
        end
        check("wait_out", 32'(cnt_out), 32'(v));
    endtask

    initial begin
        int errs;
        int pulses;
        int dones;
        cmd_bus.cmd_valid   = 1'b0;
        cmd_bus.cmd_op      = 2'd0;
        cmd_bus.cmd_div     = '0;
        cmd_bus.cmd_bounces = '0;
        rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_en",    32'(cnt_enable), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_bcnt",  32'(bounce_cnt), 0);
        check("rst_ready", 32'(cmd_bus.cmd_ready), 1);
        check("rst_out",   32'(cnt_out), 0);
        check("rst_dir",   32'(cnt_dir), 1);
        rst_n = 1'b1;

        // RUN div=0 target=1: 16 enables, then DONE
        send(2'd1, 8'd0, 4'd1);
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            if (cnt_enable !== 1'b1) errs++;
            tick();
        end
        check("run0_en16",  32'(errs), 0);
        check("run0_done",  32'(done), 1);
        check("run0_den",   32'(cnt_enable), 0);
        check("run0_dready",32'(cmd_bus.cmd_ready), 0);
        tick();
        check("run0_done2", 32'(done), 0);
        check("run0_busy",  32'(busy), 0);
        check("run0_out",   32'(cnt_out), 14);
        check("run0_dir",   32'(cnt_dir), 0);
        check("run0_bcnt",  32'(bounce_cnt), 1);

        // RUN div=3 free-run for 200 cycles from out=14 going down
        send(2'd1, 8'd3, 4'd0);
        errs = 0; pulses = 0; dones = 0;
        for (int k = 1; k <= 200; k++) begin
            if (cnt_enable !== ((k % 4) == 0)) errs++;
            if (cnt_enable) pulses++;
            if (done) dones++;
            tick();
        end
        check("div3_pattern", 32'(errs), 0);
        check("div3_pulses",  32'(pulses), 50);
        check("div3_done",    32'(dones), 0);
        check("div3_out",     32'(cnt_out), 6);
        check("div3_dir",     32'(cnt_dir), 1);
        check("div3_bcnt",    32'(bounce_cnt), 3);

        // STOP at out=7, counter must hold
        wait_out(4'd7);
        send(2'd3, 8'd0, 4'd0);
        check("stop_busy", 32'(busy), 0);
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (cnt_out != 4'd7 || cnt_enable) errs++;
            tick();
        end
        check("stop_hold", 32'(errs), 0);
        check("stop_bcnt_hold", 32'(bounce_cnt), 3);
        send(2'd1, 8'd0, 4'd0);
        check("rerun_bcnt", 32'(bounce_cnt), 0);
        check("rerun_en",   32'(cnt_enable), 1);
        send(2'd3, 8'd0, 4'd0);
        check("rerun_stop", 32'(busy), 0);
        check("rerun_out",  32'(cnt_out), 8);

        // Three STEPs from reset; a STEP offered during STEP is refused
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        errs = 0;
        for (int s = 0; s < 3; s++) begin
            cmd_bus.cmd_valid = 1'b1;
            cmd_bus.cmd_op    = 2'd2;
            tick();
            if (cmd_bus.cmd_ready !== 1'b0 || cnt_enable !== 1'b1 || busy !== 1'b1) errs++;
            tick();
            if (busy !== 1'b0 || cnt_enable !== 1'b0) errs++;
            cmd_bus.cmd_valid = 1'b0;
            cmd_bus.cmd_op    = 2'd0;
            tick();
            if (cnt_enable !== 1'b0) errs++;
            tick();
        end
        check("step_seq", 32'(errs), 0);
        check("step_out", 32'(cnt_out), 3);
        check("step_dir", 32'(cnt_dir), 1);

        // Reset mid free-run, then a second free-run through two reversals
        send(2'd1, 8'd0, 4'd0);
        wait_out(4'd9);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_en",   32'(cnt_enable), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_bcnt", 32'(bounce_cnt), 0);
        send(2'd1, 8'd0, 4'd0);
        for (int i = 0; i < 31; i++) tick();
        check("fr2_bcnt", 32'(bounce_cnt), 2);
        check("fr2_out",  32'(cnt_out), 1);
        check("fr2_dir",  32'(cnt_dir), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
